adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one 32-bit adder between NUM_REQ requesters, e.g. the PC+4 incrementer, the branch-target adder and the load/store address adder in the multicycle datapath.
- Arbitration is round-robin with a valid/ready handshake on each requester and on the response port.
- The result is registered in a one-entry output buffer tagged with the requester ID.
- Sustains one addition per cycle when the consumer does not stall.

Parameters:
- WIDTH, 32, operand and sum width.
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of the requester ID; 2^ID_W >= NUM_REQ is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant/accept.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the granted requester.
- rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
- rsp_carry  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n=0, applied asynchronously):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst_n=0.
  - A pending result is discarded; no response for it ever appears.
- can_accept = !rsp_valid || rsp_ready.
- Grant, combinational:
  - Scan indices ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - The first i with req_valid[i]=1 gets req_ready[i]=1, but only if can_accept=1.
  - All other req_ready bits are 0. req_ready is at most one-hot and never asserted without the matching req_valid.
- Transfer: occurs on a rising edge with req_valid[i] && req_ready[i].
  - rsp_sum <= low WIDTH bits of req_a[i]+req_b[i].
  - rsp_carry <= bit WIDTH of the same (WIDTH+1)-bit sum.
  - rsp_id <= i; rsp_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ.
- No transfer: ptr holds.
  - If rsp_ready=1, rsp_valid <= 0; rsp_sum, rsp_carry and rsp_id hold their old values.
- Latency: accept in cycle N gives rsp_valid=1 in cycle N+1.
- Throughput: consume and accept in the same cycle is legal, giving 1 result per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_sum, rsp_carry and rsp_id are stable.
  - All req_ready bits are 0.
- Requester rule: a requester holds req_valid and its operands until accepted. The block does not check this.
- A requester that drops req_valid before grant loses its turn silently; ptr is unaffected.
- Starvation bound: a continuously valid requester is granted within NUM_REQ accept cycles.
- No combinational path from rsp_ready to rsp_* outputs.
- A combinational path from req_valid/rsp_ready to req_ready is permitted.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- Defined: adds two outputs.
  - stat_grants, 16 bits: increments on every transfer and saturates at 0xFFFF.
  - stat_stalls, 16 bits: increments each cycle with |req_valid && !can_accept, and saturates at 0xFFFF.
  - Both counters reset to 0 asynchronously with rst_n.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then drop it again while rsp_valid=1 -> all outputs 0 immediately (before the next clk edge); after release the first grant goes to req0 when all are valid.
- Single request: req_valid=3'b001, a=4, b=12, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=16, rsp_carry=0; the cycle after, rsp_valid=0.
- Round-robin: req_valid=3'b111 held with distinct operands, rsp_ready=1 -> rsp_id sequence 0,1,2,0,1,2, rsp_valid=1 every cycle, sums match per requester.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=3'b110 -> req_ready=0 and rsp_* frozen; on rsp_ready=1, req1 is granted in that same cycle and its result follows the next cycle.
- Arithmetic edges: a=0xFFFFFFFF, b=1 -> sum=0, carry=1; a=19239859, b=5435932 -> sum=24675791, carry=0; a=b=0 -> sum=0, carry=0.
- Stats (ADDER_ARB_STATS_EN): 5 transfers plus 3 stalled cycles -> stat_grants=5, stat_stalls=3; force 0xFFFF+2 grants -> stat_grants stays 0xFFFF.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Handshake bundle between the requesters/consumer and the shared adder.
// The slave modport is the arbiter side. The master modport is the requester/consumer side.
interface adder_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder and has a one-entry tagged result buffer.
// Define ADDER_ARB_STATS_EN to add the saturating stat_grants and stat_stalls counters.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]    stat_grants,
  output logic [15:0]    stat_stalls
`endif
);

  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               can_accept;
  logic               found;
  logic               xfer;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [WIDTH:0]     sum_full;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // The lowest valid index at or above ptr wins. If there is none, the scan wraps to the lowest valid index.
  always_comb begin : grant_scan
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    found   = hi_found || lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  assign xfer = found && can_accept;

  always_comb begin
    gnt   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt[i] = xfer;
        a_sel  = bus.req_a[i*WIDTH +: WIDTH];
        b_sel  = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full      = {1'b0, a_sel} + {1'b0, b_sel};
  assign bus.req_ready = gnt & {NUM_REQ{rst_n}};

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_sum_d   = sum_full[WIDTH-1:0];
      rsp_carry_d = sum_full[WIDTH];
      ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Output buffer stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] grants_q, grants_d;
  logic [15:0] stalls_q, stalls_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    grants_d = xfer ? sat_inc(grants_q) : grants_q;
    stalls_d = (|bus.req_valid && !can_accept) ? sat_inc(stalls_q) : stalls_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter. It covers reset, single request, round-robin order, backpressure and adder edges.
// The stats counters are exercised when ADDER_ARB_STATS_EN is defined.
module tb_adder_arbiter;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  adder_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_stalls;
`endif

  adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    bus.rsp_ready = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'd4);
    set_op(1, 32'd10, 32'd20);
    set_op(2, 32'd30, 32'd40);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.rsp_valid); end n_cmp++;
    if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", bus.rsp_id); end n_cmp++;
    if (bus.rsp_sum !== 32'd0) begin n_err++; $display("FAIL rst_sum: got %0h want 0", bus.rsp_sum); end n_cmp++;
    if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL rst_carry: got %0b want 0", bus.rsp_carry); end n_cmp++;
    if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready: got %b want 000", bus.req_ready); end n_cmp++;
    rst_n = 1'b1;
    #1;
    if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL rst_first_grant: got %b want 001", bus.req_ready); end n_cmp++;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %0b want 1", bus.rsp_valid); end n_cmp++;
    if (bus.rsp_sum !== 32'd3 || bus.rsp_carry !== 1'b1) begin n_err++; $display("FAIL rst_pre_sum: got %0h/%0b want 3/1", bus.rsp_sum, bus.rsp_carry); end n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %0b want 0", bus.rsp_valid); end n_cmp++;
    if (bus.rsp_sum !== 32'd0) begin n_err++; $display("FAIL async_sum: got %0h want 0", bus.rsp_sum); end n_cmp++;
    if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL async_carry: got %0b want 0", bus.rsp_carry); end n_cmp++;
    if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL async_ready: got %b want 000", bus.req_ready); end n_cmp++;
    bus.req_valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_discard: got %0b want 0", bus.rsp_valid); end n_cmp++;
    bus.req_valid = 3'b111;
    #1;
    if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL rst_ptr0: got %b want 001", bus.req_ready); end n_cmp++;
    bus.req_valid = 3'b000;
  endtask

  task automatic test_single();
    bus.req_valid = 3'b001;
    bus.rsp_ready = 1'b1;
    set_op(0, 32'd4, 32'd12);
    #1;
    if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready: got %b want 001", bus.req_ready); end n_cmp++;
    @(negedge clk);
    bus.req_valid = 3'b000;
    if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", bus.rsp_valid); end n_cmp++;
    if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", bus.rsp_id); end n_cmp++;
    if (bus.rsp_sum !== 32'd16) begin n_err++; $display("FAIL single_sum: got %0d want 16", bus.rsp_sum); end n_cmp++;
    if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL single_carry: got %0b want 0", bus.rsp_carry); end n_cmp++;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drop: got %0b want 0", bus.rsp_valid); end n_cmp++;
    if (bus.rsp_sum !== 32'd16) begin n_err++; $display("FAIL single_hold: got %0d want 16", bus.rsp_sum); end n_cmp++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_sum [3];
    exp_sum[0] = 32'd11;
    exp_sum[1] = 32'd102;
    exp_sum[2] = 32'd1003;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set_op(0, 32'd10, 32'd1);
    set_op(1, 32'd100, 32'd2);
    set_op(2, 32'd1000, 32'd3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %0b want 1", k, bus.rsp_valid); end n_cmp++;
      if (bus.rsp_id !== 2'(k % 3)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, bus.rsp_id, k % 3); end n_cmp++;
      if (bus.rsp_sum !== exp_sum[k % 3]) begin n_err++; $display("FAIL rr_sum[%0d]: got %0d want %0d", k, bus.rsp_sum, exp_sum[k % 3]); end n_cmp++;
    end
    bus.req_valid = 3'b000;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle: got %0b want 0", bus.rsp_valid); end n_cmp++;
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 3'b001;
    set_op(0, 32'd7, 32'd8);
    @(negedge clk);
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'd15) begin n_err++; $display("FAIL bp_setup: got %0b/%0d want 1/15", bus.rsp_valid, bus.rsp_sum); end n_cmp++;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b110;
    set_op(1, 32'd50, 32'd5);
    set_op(2, 32'd60, 32'd6);
    #1;
    if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL bp_ready0: got %b want 000", bus.req_ready); end n_cmp++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, bus.rsp_valid); end n_cmp++;
      if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== 32'd15 || bus.rsp_carry !== 1'b0) begin
        n_err++; $display("FAIL bp_frozen[%0d]: got id%0d sum%0d c%0b want id0 sum15 c0", k, bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
      end n_cmp++;
      if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 000", k, bus.req_ready); end n_cmp++;
    end
    bus.rsp_ready = 1'b1;
    #1;
    if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL bp_release: got %b want 010", bus.req_ready); end n_cmp++;
    @(negedge clk);
    if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'd55) begin n_err++; $display("FAIL bp_req1: got id%0d sum%0d want id1 sum55", bus.rsp_id, bus.rsp_sum); end n_cmp++;
    #1;
    if (bus.req_ready !== 3'b100) begin n_err++; $display("FAIL bp_next: got %b want 100", bus.req_ready); end n_cmp++;
    @(negedge clk);
    bus.req_valid = 3'b000;
    if (bus.rsp_id !== 2'd2 || bus.rsp_sum !== 32'd66) begin n_err++; $display("FAIL bp_req2: got id%0d sum%0d want id2 sum66", bus.rsp_id, bus.rsp_sum); end n_cmp++;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %0b want 0", bus.rsp_valid); end n_cmp++;
  endtask

  task automatic test_arith();
    logic [2:0]  vld [4];
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    logic [31:0] es  [4];
    logic        ec  [4];
    logic [1:0]  eid [4];
    vld[0] = 3'b001; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;        es[0] = 32'd0;        ec[0] = 1'b1; eid[0] = 2'd0;
    vld[1] = 3'b100; a[1] = 32'd0;         b[1] = 32'd0;        es[1] = 32'd0;        ec[1] = 1'b0; eid[1] = 2'd2;
    vld[2] = 3'b010; a[2] = 32'd19239859;  b[2] = 32'd5435932;  es[2] = 32'd24675791; ec[2] = 1'b0; eid[2] = 2'd1;
    vld[3] = 3'b100; a[3] = 32'h8000_0001; b[3] = 32'h8000_0003; es[3] = 32'd4;       ec[3] = 1'b1; eid[3] = 2'd2;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = vld[k];
      set_op(int'(eid[k]), a[k], b[k]);
      @(negedge clk);
      if (bus.rsp_sum !== es[k]) begin n_err++; $display("FAIL arith_sum[%0d]: got %0h want %0h", k, bus.rsp_sum, es[k]); end n_cmp++;
      if (bus.rsp_carry !== ec[k]) begin n_err++; $display("FAIL arith_carry[%0d]: got %0b want %0b", k, bus.rsp_carry, ec[k]); end n_cmp++;
      if (bus.rsp_id !== eid[k]) begin n_err++; $display("FAIL arith_id[%0d]: got %0d want %0d", k, bus.rsp_id, eid[k]); end n_cmp++;
    end
    bus.req_valid = 3'b000;
    @(negedge clk);
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    if (stat_grants !== 16'd0 || stat_stalls !== 16'd0) begin n_err++; $display("FAIL stats_rst: got %0d/%0d want 0/0", stat_grants, stat_stalls); end n_cmp++;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 3'b001;
    set_op(0, 32'd1, 32'd1);
    repeat (5) @(negedge clk);
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_valid = 3'b000;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    if (stat_grants !== 16'd5) begin n_err++; $display("FAIL stats_grants: got %0d want 5", stat_grants); end n_cmp++;
    if (stat_stalls !== 16'd3) begin n_err++; $display("FAIL stats_stalls: got %0d want 3", stat_stalls); end n_cmp++;
    bus.req_valid = 3'b001;
    repeat (65537) @(negedge clk);
    bus.req_valid = 3'b000;
    @(negedge clk);
    if (stat_grants !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat: got %0h want ffff", stat_grants); end n_cmp++;
  endtask
`endif

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_arith();
`ifdef ADDER_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
